ima_adpcm_blk_ctrl: RTL and testbench

IMA_ADPCM_BLK_CTRL -- requirements
Module: ima_adpcm_blk_ctrl

---
 rtl/ima_adpcm_blk_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ima_adpcm_blk_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ima_adpcm_blk_ctrl.sv
// IMA ADPCM block sequencer: parses the 4-byte block header, loads decoder state, feeds data nibbles lo-then-hi.
// Latency: header sample is emitted in the LOAD cycle; decoder samples are passed through one cycle late.
// Backpressure: inReady only in header/FETCH states; nibbles are held until decReady, sources hold unaccepted bytes.
module ima_adpcm_blk_ctrl #(
  parameter int BLOCK_BYTES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  output logic [3:0]  decPCM,
  output logic        decValid,
  input  logic        decReady,
  output logic [15:0] decPredictSamp,
  output logic [6:0]  decStepIndex,
  output logic        decStateLoad,
  input  logic [15:0] decSamp,
  input  logic        decSampValid,
  output logic [15:0] outSamp,
  output logic        outValid,
  output logic        outFirst,
  output logic        blkDone,
  output logic        errStep
);

  // Number of data bytes following the header; the counter is compared
  // against it after the increment on each FETCH acceptance.
  localparam logic [9:0] LAST_CNT = 10'(BLOCK_BYTES - 4);
  localparam logic [6:0] MAX_STEP = 7'd88;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    HDR2,
    HDR3,
    LOAD,
    FETCH,
    NIB_LO,
    NIB_HI
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pred_q, pred_d;
  logic [6:0]  step_q, step_d;
  logic        clamp_q, clamp_d;
  logic [7:0]  byte_q, byte_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [15:0] pt_samp_q, pt_samp_d;
  logic        pt_vld_q, pt_vld_d;
  logic        load_out;

  // Next-state, datapath capture and all outputs of the block sequencer.
  always_comb begin
    state_d        = state_q;
    pred_d         = pred_q;
    step_d         = step_q;
    clamp_d        = clamp_q;
    byte_d         = byte_q;
    cnt_d          = cnt_q;
    pend_d         = pend_q;
    pt_samp_d      = decSamp;
    pt_vld_d       = decSampValid;
    load_out       = 1'b0;
    inReady        = 1'b0;
    decPCM         = 4'd0;
    decValid       = 1'b0;
    decStateLoad   = 1'b0;
    errStep        = 1'b0;
    decPredictSamp = pred_q;
    decStepIndex   = step_q;

    // The end-of-block marker rides on the first pass-through sample
    // after the final nibble was handed to the decoder.
    blkDone = pend_q && pt_vld_q;
    if (blkDone) begin
      pend_d = 1'b0;
    end

    case (state_q)
      HDR0: begin
        inReady = 1'b1;
        if (inValid) begin
          pred_d[7:0] = inData;
          state_d     = HDR1;
        end
      end
      HDR1: begin
        inReady = 1'b1;
        if (inValid) begin
          pred_d[15:8] = inData;
          state_d      = HDR2;
        end
      end
      HDR2: begin
        inReady = 1'b1;
        if (inValid) begin
          // Bit 7 is reserved; out-of-table indices are clamped and flagged.
          if (inData[6:0] > MAX_STEP) begin
            step_d  = MAX_STEP;
            clamp_d = 1'b1;
          end else begin
            step_d  = inData[6:0];
            clamp_d = 1'b0;
          end
          state_d = HDR3;
        end
      end
      HDR3: begin
        inReady = 1'b1;
        if (inValid) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        decStateLoad = 1'b1;
        errStep      = clamp_q;
        load_out     = 1'b1;
        cnt_d        = 10'd0;
        state_d      = FETCH;
      end
      FETCH: begin
        inReady = 1'b1;
        if (inValid) begin
          byte_d  = inData;
          cnt_d   = cnt_q + 10'd1;
          state_d = NIB_LO;
        end
      end
      NIB_LO: begin
        decPCM   = byte_q[3:0];
        decValid = decReady;
        if (decReady) begin
          state_d = NIB_HI;
        end
      end
      NIB_HI: begin
        decPCM   = byte_q[7:4];
        decValid = decReady;
        if (decReady) begin
          if (cnt_q == LAST_CNT) begin
            state_d = HDR0;
            pend_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = HDR0;
      end
    endcase

    // The header sample owns the output in LOAD; the decoder has drained
    // during the header bytes so no pass-through sample is lost here.
    outValid = load_out | pt_vld_q;
    outFirst = load_out;
    outSamp  = load_out ? pred_q : pt_samp_q;

    // Everything is quiet while reset is held.
    if (reset) begin
      inReady        = 1'b0;
      decPCM         = 4'd0;
      decValid       = 1'b0;
      decStateLoad   = 1'b0;
      errStep        = 1'b0;
      decPredictSamp = 16'd0;
      decStepIndex   = 7'd0;
      outValid       = 1'b0;
      outFirst       = 1'b0;
      outSamp        = 16'd0;
      blkDone        = 1'b0;
    end
  end

  // State, header capture, byte counter, pending flag and pass-through registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= HDR0;
      pred_q    <= 16'd0;
      step_q    <= 7'd0;
      clamp_q   <= 1'b0;
      byte_q    <= 8'd0;
      cnt_q     <= 10'd0;
      pend_q    <= 1'b0;
      pt_samp_q <= 16'd0;
      pt_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      step_q    <= step_d;
      clamp_q   <= clamp_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pt_samp_q <= pt_samp_d;
      pt_vld_q  <= pt_vld_d;
    end
  end

endmodule

// File: tb/tb_ima_adpcm_blk_ctrl.sv
// Bench for ima_adpcm_blk_ctrl with an 8-byte block: random and directed blocks
// checked against a queue-based model of the expected decoder loads, nibbles
// and output samples.
module tb_ima_adpcm_blk_ctrl;

  localparam int BB = 8;

  logic        clock;
  logic        reset;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic [3:0]  decPCM;
  logic        decValid;
  logic        decReady;
  logic [15:0] decPredictSamp;
  logic [6:0]  decStepIndex;
  logic        decStateLoad;
  logic [15:0] decSamp;
  logic        decSampValid;
  logic [15:0] outSamp;
  logic        outValid;
  logic        outFirst;
  logic        blkDone;
  logic        errStep;

  ima_adpcm_blk_ctrl #(.BLOCK_BYTES(BB)) dut (
    .clock          (clock),
    .reset          (reset),
    .inData         (inData),
    .inValid        (inValid),
    .inReady        (inReady),
    .decPCM         (decPCM),
    .decValid       (decValid),
    .decReady       (decReady),
    .decPredictSamp (decPredictSamp),
    .decStepIndex   (decStepIndex),
    .decStateLoad   (decStateLoad),
    .decSamp        (decSamp),
    .decSampValid   (decSampValid),
    .outSamp        (outSamp),
    .outValid       (outValid),
    .outFirst       (outFirst),
    .blkDone        (blkDone),
    .errStep        (errStep)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Stand-in decoder: answers every nibble in the same cycle with a sample
  // tagging the nibble's global sequence number and its value.
  logic [11:0] nib_seq = 12'd0;
  assign decSampValid = decValid;
  assign decSamp      = {nib_seq, decPCM};
  always @(posedge clock) if (decValid) nib_seq <= nib_seq + 12'd1;

  typedef struct {
    logic [15:0] pred;
    logic [6:0]  idx;
    logic        err;
  } ld_t;

  typedef struct {
    logic [15:0] samp;
    logic        first;
    logic        done;
  } out_t;

  ld_t        exp_ld[$];
  logic [3:0] exp_nib[$];
  out_t       exp_out[$];
  int         model_seq = 0;

  int vectors = 0;
  int miscompares = 0;
  bit dr_always = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decoder readiness: mostly ready, or always ready in streaming phases.
  initial begin
    decReady = 1'b0;
    forever begin
      @(negedge clock);
      decReady = dr_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Observe loads, nibbles and output samples against the model queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (decStateLoad) begin
        chk("ld_inrdy", inReady, 0);
        chk("ld_decvld", decValid, 0);
        if (exp_ld.size() == 0) chk("ld_unexp", decStateLoad, 0);
        else begin
          ld_t e;
          e = exp_ld.pop_front();
          chk("ld_pred", decPredictSamp, e.pred);
          chk("ld_idx", decStepIndex, e.idx);
          chk("ld_err", errStep, e.err);
        end
      end else if (errStep) begin
        chk("err_lone", errStep, 0);
      end
      if (decValid) begin
        chk("nib_decrdy", decReady, 1);
        chk("nib_inrdy", inReady, 0);
        if (exp_nib.size() == 0) chk("nib_unexp", decValid, 0);
        else chk("nib_val", decPCM, exp_nib.pop_front());
      end
      if (outValid) begin
        if (exp_out.size() == 0) chk("out_unexp", outValid, 0);
        else begin
          out_t o;
          o = exp_out.pop_front();
          chk("out_samp", outSamp, o.samp);
          chk("out_first", outFirst, o.first);
          chk("out_done", blkDone, o.done);
        end
      end else if (blkDone) begin
        chk("done_lone", blkDone, 0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit hold);
    int n = 0;
    inData  = b;
    inValid = 1'b1;
    while (!inReady && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) chk("send_timeout", n, 0);
    @(negedge clock);
    if (!hold) inValid = 1'b0;
  endtask

  // Queue the expectations for a block (or its first nsend bytes), then send it.
  task automatic run_block(input logic [7:0] blk [BB], input int nsend,
                           input bit cont, input bit hold_last);
    ld_t  l;
    out_t o;
    logic [3:0] nib;
    l.pred = {blk[1], blk[0]};
    l.idx  = (blk[2][6:0] > 7'd88) ? 7'd88 : blk[2][6:0];
    l.err  = (blk[2][6:0] > 7'd88);
    exp_ld.push_back(l);
    o.samp = l.pred; o.first = 1'b1; o.done = 1'b0;
    exp_out.push_back(o);
    for (int i = 4; i < nsend; i++) begin
      for (int h = 0; h < 2; h++) begin
        nib = (h == 0) ? blk[i][3:0] : blk[i][7:4];
        exp_nib.push_back(nib);
        o.samp  = {model_seq[11:0], nib};
        o.first = 1'b0;
        o.done  = (i == BB - 1) && (h == 1);
        exp_out.push_back(o);
        model_seq++;
      end
    end
    for (int j = 0; j < nsend; j++) begin
      if (!cont) repeat ($urandom_range(0, 3)) @(negedge clock);
      send_byte(blk[j], cont && ((j != nsend - 1) || hold_last));
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_out.size() != 0 || exp_nib.size() != 0 || exp_ld.size() != 0) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    chk({tag, "_out_left"}, exp_out.size(), 0);
    chk({tag, "_nib_left"}, exp_nib.size(), 0);
  endtask

  task automatic rand_block(output logic [7:0] b [BB]);
    for (int i = 0; i < BB; i++) b[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    logic [7:0] b [BB];
    reset   = 1'b1;
    inData  = 8'd0;
    inValid = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_inrdy", inReady, 0);
    chk("rst_outvld", outValid, 0);
    chk("rst_decvld", decValid, 0);
    chk("rst_load", decStateLoad, 0);
    chk("rst_done", blkDone, 0);
    chk("rst_samp", outSamp, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_inrdy", inReady, 1);

    // Known header and data byte 0x7A.
    b = '{8'h34, 8'h12, 8'h05, 8'h00, 8'h7A, 8'h00, 8'h00, 8'h00};
    for (int i = 5; i < BB; i++) b[i] = 8'($urandom_range(0, 255));
    run_block(b, BB, 1'b0, 1'b0);
    wait_drain("hdr1234");

    // Step index out of table range.
    rand_block(b);
    b[2] = 8'h60;
    run_block(b, BB, 1'b0, 1'b0);
    wait_drain("clamp");

    // Random blocks, random gaps and decoder stalls.
    for (int k = 0; k < 20; k++) begin
      rand_block(b);
      if (k % 5 == 0) b[2] = 8'hD8;
      run_block(b, BB, 1'b0, 1'b0);
    end
    wait_drain("random");

    // Source streaming with inValid held high across several blocks.
    dr_always = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_block(b);
      run_block(b, BB, 1'b1, k != 2);
    end
    wait_drain("stream");
    dr_always = 1'b0;

    // Abandon a block after two data bytes, then start fresh.
    rand_block(b);
    run_block(b, 6, 1'b0, 1'b0);
    wait_drain("partial");
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_inrdy", inReady, 1);
    b = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 4; i < BB; i++) b[i] = 8'($urandom_range(0, 255));
    run_block(b, BB, 1'b0, 1'b0);
    wait_drain("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
